// File: rtl/cve2_multdiv_iter.sv
// Iterative RV32M multiply/divide unit. It computes every sum through the ALU's shared adder.
// Operation latency is fixed and does not depend on operand values:
//   - multiply: 1 accept + 32 shift-add + 1 sign correction, result at accept + 34 cycles;
//   - divide: 1 accept + 2 abs + 32 restoring steps + 1 sign fix, result at accept + 36 cycles.
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   mult_en_i, div_en_i      request levels, held until valid_o (multiply has priority)
//   md_op_i                  MUL/MULH/MULHSU/MULHU or DIV/DIVU/REM/REMU
//   op_a_i, op_b_i           rs1, rs2
//   alu_adder_ext_i          ALU adder result, [33:1] = operand_a + operand_b (33 bit)
//   multdiv_operand_a/b_o    adder operands, zero while multdiv_sel_o is low
//   multdiv_sel_o            ALU adder owned by this block
//   valid_o, result_o        one-cycle result strobe and held result
module cve2_multdiv_iter (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mult_en_i,
  input  logic        div_en_i,
  input  logic [1:0]  md_op_i,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  input  logic [33:0] alu_adder_ext_i,
  output logic [32:0] multdiv_operand_a_o,
  output logic [32:0] multdiv_operand_b_o,
  output logic        multdiv_sel_o,
  output logic        valid_o,
  output logic [31:0] result_o
);

  typedef enum logic [2:0] {
    StIdle, StMulIter, StMulLast, StDivAbsA, StDivAbsB, StDivIter, StDivFix, StDone
  } state_e;

  state_e      r_state, w_state_next;
  logic [4:0]  r_cnt;
  logic [32:0] r_acc;       // multiply: high partial product; divide: remainder
  logic [32:0] r_a;         // multiply: multiplicand; divide: dividend, then quotient
  logic [31:0] r_b;         // multiply: multiplier, then low product; divide: divisor
  logic [1:0]  r_op;
  logic        r_is_div, r_a_signed, r_neg_a, r_neg_b, r_div_zero;
  logic [31:0] r_result;

  logic        w_a_signed, w_b_signed, w_active_en, w_div_neg, w_fix_neg, w_unused_adder_lsb;
  logic [32:0] w_sum, w_rem_shift, w_fix_src, w_op_a, w_op_b;
  logic        w_sel;

  assign w_sum              = alu_adder_ext_i[33:1];
  assign w_div_neg          = alu_adder_ext_i[33];  // trial subtraction went negative
  assign w_unused_adder_lsb = alu_adder_ext_i[0];
  assign w_active_en        = r_is_div ? div_en_i : mult_en_i;
  assign w_rem_shift        = {r_acc[31:0], r_a[31]};
  assign w_fix_src          = {1'b0, (r_op[1] ? r_acc[31:0] : r_a[31:0])};
  // Remainder follows the dividend sign; quotient of a divide by zero stays all ones.
  assign w_fix_neg          = r_op[1] ? r_neg_a : ((r_neg_a ^ r_neg_b) & ~r_div_zero);

  always_comb begin
    w_a_signed = 1'b0;
    w_b_signed = 1'b0;
    if (mult_en_i) begin
      w_a_signed = (md_op_i == 2'b01) || (md_op_i == 2'b10);
      w_b_signed = (md_op_i == 2'b01);
    end else begin
      w_a_signed = ~md_op_i[0];
      w_b_signed = ~md_op_i[0];
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_op_a       = '0;
    w_op_b       = '0;
    w_sel        = 1'b1;
    unique case (r_state)
      StIdle: begin
        w_sel = 1'b0;
        if (mult_en_i)     w_state_next = StMulIter;
        else if (div_en_i) w_state_next = StDivAbsA;
      end
      StMulIter: begin
        w_op_a = r_acc;
        w_op_b = r_b[0] ? r_a : '0;
        if (r_cnt == 5'd0) w_state_next = StMulLast;
      end
      StMulLast: begin
        // Multiplier sign bit weighs -2^32: subtract the multiplicand from the high half.
        w_op_a       = r_acc;
        w_op_b       = r_neg_b ? (~r_a + 33'd1) : '0;
        w_state_next = StDone;
      end
      StDivAbsA: begin
        w_op_b       = r_neg_a ? (~r_a + 33'd1) : r_a;
        w_state_next = StDivAbsB;
      end
      StDivAbsB: begin
        w_op_b       = r_neg_b ? (~{1'b0, r_b} + 33'd1) : {1'b0, r_b};
        w_state_next = StDivIter;
      end
      StDivIter: begin
        w_op_a = w_rem_shift;
        w_op_b = ~{1'b0, r_b} + 33'd1;
        if (r_cnt == 5'd0) w_state_next = StDivFix;
      end
      StDivFix: begin
        w_op_b       = w_fix_neg ? (~w_fix_src + 33'd1) : w_fix_src;
        w_state_next = StDone;
      end
      StDone: begin
        w_sel        = 1'b0;
        w_state_next = StIdle;
      end
      default: begin
        w_sel        = 1'b0;
        w_state_next = StIdle;
      end
    endcase
    if ((r_state != StIdle) && (r_state != StDone) && !w_active_en) w_state_next = StIdle;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= StIdle;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt      <= '0;
      r_acc      <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_op       <= '0;
      r_is_div   <= 1'b0;
      r_a_signed <= 1'b0;
      r_neg_a    <= 1'b0;
      r_neg_b    <= 1'b0;
      r_div_zero <= 1'b0;
      r_result   <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (mult_en_i || div_en_i) begin
            r_is_div   <= ~mult_en_i;
            r_op       <= md_op_i;
            r_a        <= {w_a_signed & op_a_i[31], op_a_i};
            r_b        <= op_b_i;
            r_acc      <= '0;
            r_cnt      <= 5'd31;
            r_a_signed <= w_a_signed;
            r_neg_a    <= w_a_signed & op_a_i[31];
            r_neg_b    <= w_b_signed & op_b_i[31];
            r_div_zero <= (op_b_i == 32'd0);
          end
        end
        StMulIter: begin
          // Partial sum fits 33 bits as signed or unsigned, matching the multiplicand.
          r_acc <= {(r_a_signed ? w_sum[32] : 1'b0), w_sum[32:1]};
          r_b   <= {w_sum[0], r_b[31:1]};
          r_cnt <= r_cnt - 5'd1;
        end
        StMulLast: begin
          if (w_active_en) r_result <= (r_op == 2'b00) ? r_b : w_sum[31:0];
        end
        StDivAbsA: r_a <= {1'b0, w_sum[31:0]};
        StDivAbsB: begin
          r_b   <= w_sum[31:0];
          r_acc <= '0;
          r_cnt <= 5'd31;
        end
        StDivIter: begin
          r_acc <= w_div_neg ? w_rem_shift : w_sum;
          r_a   <= {1'b0, r_a[30:0], ~w_div_neg};
          r_cnt <= r_cnt - 5'd1;
        end
        StDivFix: begin
          if (w_active_en) r_result <= w_sum[31:0];
        end
        default: ;
      endcase
    end
  end

  assign multdiv_operand_a_o = w_op_a;
  assign multdiv_operand_b_o = w_op_b;
  assign multdiv_sel_o       = w_sel;
  assign valid_o             = (r_state == StDone);
  assign result_o            = r_result;

endmodule

// File: tb/tb_cve2_multdiv_iter.sv
// Self-checking bench for cve2_multdiv_iter: directed vector table, abort/reset sequences and
// random operations, with results and latencies checked through a scoreboard queue.
module tb_cve2_multdiv_iter;

  logic        clk_i = 1'b0;
  logic        rst_i, mult_en_i, div_en_i;
  logic [1:0]  md_op_i;
  logic [31:0] op_a_i, op_b_i, result_o;
  logic [33:0] alu_adder_ext;
  logic [32:0] multdiv_operand_a_o, multdiv_operand_b_o;
  logic        multdiv_sel_o, valid_o;

  always #5 clk_i = ~clk_i;

  // ALU adder model: plain 33-bit addition, result in bits [33:1].
  assign alu_adder_ext = {33'(multdiv_operand_a_o + multdiv_operand_b_o), 1'b0};

  cve2_multdiv_iter dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .mult_en_i           (mult_en_i),
    .div_en_i            (div_en_i),
    .md_op_i             (md_op_i),
    .op_a_i              (op_a_i),
    .op_b_i              (op_b_i),
    .alu_adder_ext_i     (alu_adder_ext),
    .multdiv_operand_a_o (multdiv_operand_a_o),
    .multdiv_operand_b_o (multdiv_operand_b_o),
    .multdiv_sel_o       (multdiv_sel_o),
    .valid_o             (valid_o),
    .result_o            (result_o)
  );

  typedef struct {
    logic [31:0] exp;
    int          k;
    int          lat;
    int          id;
  } sb_t;

  typedef struct {
    logic        m;
    logic        d;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  sb_t         scoreboard[$];
  vec_t        vecs[$];
  sb_t         e;
  int          n_checks = 0, n_fail = 0, n_valid = 0, n_ops = 0, cyc = 0;
  logic [31:0] last_exp = '0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (time %0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic is_div, input logic [1:0] op,
                                            input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ax, bx, p;
    int          sa, sbv;
    if (!is_div) begin
      ax = (op == 2'b01 || op == 2'b10) ? {{32{a[31]}}, a} : {32'b0, a};
      bx = (op == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
      p  = ax * bx;
      return (op == 2'b00) ? p[31:0] : p[63:32];
    end
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
      sa  = a;
      sbv = b;
      return op[1] ? 32'(sa % sbv) : 32'(sa / sbv);
    end
    return op[1] ? (a % b) : (a / b);
  endfunction

  // Scoreboard consumer: every valid pulse must match the oldest outstanding operation.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (valid_o) begin
        n_valid++;
        if (scoreboard.size() == 0) begin
          check("unexpected_valid", {63'b0, valid_o}, 64'd0);
        end else begin
          e = scoreboard.pop_front();
          check($sformatf("result[op%0d]", e.id), {32'b0, result_o}, {32'b0, e.exp});
          check($sformatf("latency[op%0d]", e.id), 64'(cyc - e.k), 64'(e.lat));
          last_exp = e.exp;
        end
      end
      if (!multdiv_sel_o) begin
        check("idle_operand_a_zero", {31'b0, multdiv_operand_a_o}, 64'd0);
        check("idle_operand_b_zero", {31'b0, multdiv_operand_b_o}, 64'd0);
      end
    end
  end

  task automatic drive(input logic m, input logic d, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input bit push);
    @(posedge clk_i);
    #1;
    mult_en_i = m;
    div_en_i  = d;
    md_op_i   = op;
    op_a_i    = a;
    op_b_i    = b;
    if (push) scoreboard.push_back('{exp, cyc, (m ? 34 : 36), n_ops});
    n_ops++;
  endtask

  task automatic wait_valid(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk_i);
      seen = valid_o;
    end
    if (!seen) begin
      check({name, "_timeout"}, {63'b0, valid_o}, 64'd1);
      scoreboard.delete();
      mult_en_i = 1'b0;
      div_en_i  = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
      mult_en_i = 1'b0;
      div_en_i  = 1'b0;
    end
  endtask

  task automatic add_vec(input logic m, input logic d, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
    vecs.push_back('{m, d, op, a, b, exp});
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h0000_0001;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [35:0] sel_pat, val_pat;
    logic [31:0] ra, rb;
    logic [1:0]  rop;
    logic        rm, rd;
    int          nv, gap;

    add_vec(1, 0, 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    add_vec(1, 0, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    add_vec(1, 0, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    add_vec(1, 0, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
    add_vec(1, 0, 2'b11, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001);
    add_vec(1, 0, 2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF);
    add_vec(1, 0, 2'b10, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000);
    add_vec(1, 0, 2'b00, 32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFE_0001);
    add_vec(1, 1, 2'b00, 32'h0000_0003, 32'h0000_0005, 32'h0000_000F);
    add_vec(0, 1, 2'b00, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD);
    add_vec(0, 1, 2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF);
    add_vec(0, 1, 2'b01, 32'd100, 32'd7, 32'd14);
    add_vec(0, 1, 2'b11, 32'd100, 32'd7, 32'd2);
    add_vec(0, 1, 2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF);
    add_vec(0, 1, 2'b10, 32'd5, 32'd0, 32'd5);
    add_vec(0, 1, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    add_vec(0, 1, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
    add_vec(0, 1, 2'b00, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF);
    add_vec(0, 1, 2'b10, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9);
    add_vec(0, 1, 2'b01, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF);
    add_vec(0, 1, 2'b11, 32'hDEAD_BEEF, 32'd0, 32'hDEAD_BEEF);
    add_vec(0, 1, 2'b00, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
    add_vec(0, 1, 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1);
    add_vec(0, 1, 2'b00, 32'h8000_0000, 32'd2, 32'hC000_0000);
    add_vec(0, 1, 2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF);
    add_vec(0, 1, 2'b11, 32'hFFFF_FFFF, 32'h10, 32'hF);

    rst_i     = 1'b1;
    mult_en_i = 1'b0;
    div_en_i  = 1'b0;
    md_op_i   = 2'b00;
    op_a_i    = '0;
    op_b_i    = '0;
    repeat (3) @(posedge clk_i);
    #1;
    check("reset_valid", {63'b0, valid_o}, 64'd0);
    check("reset_result", {32'b0, result_o}, 64'd0);
    check("reset_sel", {63'b0, multdiv_sel_o}, 64'd0);
    check("reset_operand_a", {31'b0, multdiv_operand_a_o}, 64'd0);
    check("reset_operand_b", {31'b0, multdiv_operand_b_o}, 64'd0);
    rst_i = 1'b0;

    // First MUL: cycle-accurate view of the adder select and valid strobe.
    drive(1, 0, 2'b00, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1);
    sel_pat = '0;
    val_pat = '0;
    for (int c = 0; c < 36; c++) begin
      @(negedge clk_i);
      sel_pat[c] = multdiv_sel_o;
      val_pat[c] = valid_o;
      if (valid_o) mult_en_i = 1'b0;
    end
    check("mul_sel_window", {28'b0, sel_pat}, 64'h3_FFFF_FFFE);
    check("mul_valid_window", {28'b0, val_pat}, 64'h4_0000_0000);

    // Table vectors, issued back to back.
    foreach (vecs[i]) begin
      drive(vecs[i].m, vecs[i].d, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, 1);
      wait_valid($sformatf("vec%0d", i));
    end
    idle(2);

    // Abort: drop div_en_i at k+10.
    drive(0, 1, 2'b00, 32'd100, 32'd7, 32'd0, 0);
    repeat (10) begin
      @(posedge clk_i);
      #1;
    end
    check("abort_busy_sel", {63'b0, multdiv_sel_o}, 64'd1);
    div_en_i = 1'b0;
    nv       = n_valid;
    @(posedge clk_i);
    #1;
    check("abort_idle_sel", {63'b0, multdiv_sel_o}, 64'd0);
    repeat (45) @(posedge clk_i);
    #1;
    check("abort_no_valid", 64'(n_valid), 64'(nv));
    check("abort_result_held", {32'b0, result_o}, {32'b0, last_exp});

    // Reset at k+20 of a MUL.
    drive(1, 0, 2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 1);
    repeat (20) begin
      @(posedge clk_i);
      #1;
    end
    rst_i     = 1'b1;
    mult_en_i = 1'b0;
    @(posedge clk_i);
    #1;
    scoreboard.delete();
    check("midreset_valid", {63'b0, valid_o}, 64'd0);
    check("midreset_result", {32'b0, result_o}, 64'd0);
    check("midreset_sel", {63'b0, multdiv_sel_o}, 64'd0);
    check("midreset_operand_a", {31'b0, multdiv_operand_a_o}, 64'd0);
    check("midreset_operand_b", {31'b0, multdiv_operand_b_o}, 64'd0);
    rst_i = 1'b0;
    drive(1, 0, 2'b00, 32'h0001_2345, 32'h10, 32'h0012_3450, 1);
    wait_valid("post_reset_mul");
    idle(1);

    // Random operations with random gaps.
    for (int n = 0; n < 300; n++) begin
      gap = $urandom_range(0, 3);
      if (gap > 0) idle(gap);
      rm  = 1'($urandom_range(0, 1));
      rd  = rm ? ($urandom_range(0, 9) == 0) : 1'b1;
      rop = 2'($urandom_range(0, 3));
      ra  = pick_operand();
      rb  = pick_operand();
      drive(rm, rd, rop, ra, rb, ref_model(~rm, rop, ra, rb), 1);
      wait_valid($sformatf("rand%0d", n));
    end
    idle(3);
    check("scoreboard_drained", 64'(scoreboard.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
